// File: rtl/aidc_pkt_framer.sv
// aidc_pkt_framer
//   Frames an unframed beat stream into packets. Each packet's length comes
//   from a separate command. The result is a valid/ready stream with sop/last
//   markers. Output beats pass through a 2-entry FIFO, so ready_i never
//   reaches in_ready_o or cmd_ready_o combinationally.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   cmd_valid_i/cmd_ready_o     length command handshake
//   cmd_len_i [LEN_W]           packet length in beats minus 1
//   in_valid_i/in_ready_o       input beat handshake
//   in_data_i [DATA_W]          input beat data
//   valid_o/ready_i             output beat handshake
//   data_o [DATA_W]             output beat data (head of FIFO)
//   last_o, sop_o               last / first beat of packet
//   pkt_cnt_o [CNT_W]           packets fully emitted (wraps)
//   busy_o                      packet in progress or FIFO non-empty
module aidc_pkt_framer #(
  parameter int DATA_W = 64,
  parameter int LEN_W  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [LEN_W-1:0]  cmd_len_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic              last_o,
  output logic              sop_o,
  output logic [CNT_W-1:0]  pkt_cnt_o,
  output logic              busy_o
);

  typedef enum logic {IDLE, XFER} state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   remaining_q, remaining_d;
  logic               first_q, first_d;
  logic               push_p0;

  logic [DATA_W-1:0]  data_p1 [2];
  logic               last_p1 [2];
  logic               sop_p1  [2];
  logic               rd_ptr_p1, wr_ptr_p1;
  logic [1:0]         count_p1;
  logic               vld_p1;
  logic               pop_p1;

  // ---- stage p0: command / beat acceptance
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    first_d     = first_q;
    cmd_ready_o = 1'b0;
    in_ready_o  = 1'b0;
    push_p0     = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          remaining_d = cmd_len_i;
          first_d     = 1'b1;
          state_d     = XFER;
        end
      end
      XFER: begin
        // Depends only on registered FIFO occupancy, never on ready_i.
        in_ready_o = (count_p1 < 2'd2);
        if (in_valid_i && in_ready_o) begin
          push_p0 = 1'b1;
          first_d = 1'b0;
          if (remaining_q == '0) state_d = IDLE;
          else                   remaining_d = remaining_q - LEN_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      first_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      first_q     <= first_d;
    end
  end

  // ---- stage p1: 2-entry output FIFO
  assign vld_p1 = (count_p1 != 2'd0);
  assign pop_p1 = vld_p1 & ready_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_p1 <= 1'b0;
      wr_ptr_p1 <= 1'b0;
      count_p1  <= 2'd0;
      pkt_cnt_o <= '0;
    end else begin
      if (push_p0) wr_ptr_p1 <= ~wr_ptr_p1;
      if (pop_p1)  rd_ptr_p1 <= ~rd_ptr_p1;
      case ({push_p0, pop_p1})
        2'b10:   count_p1 <= count_p1 + 2'd1;
        2'b01:   count_p1 <= count_p1 - 2'd1;
        default: count_p1 <= count_p1;
      endcase
      if (pop_p1 && last_p1[rd_ptr_p1]) pkt_cnt_o <= pkt_cnt_o + CNT_W'(1);
    end
  end

  // Payload storage carries no reset; occupancy gates its visibility.
  always_ff @(posedge clk) begin
    if (push_p0) begin
      data_p1[wr_ptr_p1] <= in_data_i;
      last_p1[wr_ptr_p1] <= (remaining_q == '0);
      sop_p1[wr_ptr_p1]  <= first_q;
    end
  end

  assign valid_o = vld_p1;
  assign data_o  = data_p1[rd_ptr_p1];
  assign last_o  = last_p1[rd_ptr_p1];
  assign sop_o   = sop_p1[rd_ptr_p1];
  assign busy_o  = (state_q == XFER) | vld_p1;

endmodule

// File: tb/tb_aidc_pkt_framer.sv
// Testbench for aidc_pkt_framer: a scoreboard of expected output beats plus
// table-driven packet vectors and hand-written corner sequences.
module tb_aidc_pkt_framer;
  localparam int DATA_W = 64;
  localparam int LEN_W  = 4;
  localparam int CNT_W  = 2;

  logic              clk, rst_n;
  logic              cmd_valid_i, cmd_ready_o;
  logic [LEN_W-1:0]  cmd_len_i;
  logic              in_valid_i, in_ready_o;
  logic [DATA_W-1:0] in_data_i;
  logic              valid_o, ready_i;
  logic [DATA_W-1:0] data_o;
  logic              last_o, sop_o;
  logic [CNT_W-1:0]  pkt_cnt_o;
  logic              busy_o;

  aidc_pkt_framer #(.DATA_W(DATA_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_len_i(cmd_len_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o),
    .last_o(last_o), .sop_o(sop_o), .pkt_cnt_o(pkt_cnt_o), .busy_o(busy_o)
  );

  typedef struct packed {logic [63:0] data; logic last; logic sop;} beat_t;
  typedef struct {int len; logic [63:0] base; bit rr; int exp_beats; int exp_cnt;} vec_t;

  beat_t            sb[$];
  int               n_chk = 0, n_pass = 0;
  int               cyc = 0;
  logic [CNT_W-1:0] mdl_cnt = '0;
  int               out_beats = 0;
  int               last_pop_edge = -1;
  bit               rand_rdy = 0;
  logic             rdy_val = 1'b1;
  bit               stall_q = 0;
  beat_t            held;

  initial begin clk = 1'b0; forever #5 clk = ~clk; end
  initial forever begin @(posedge clk); cyc++; end

  // ready_i is applied 2 time units after the edge so the main thread can
  // change rdy_val at +1 and have it take effect in the same cycle.
  initial begin
    ready_i = 1'b1;
    forever begin
      @(posedge clk); #2;
      ready_i = rand_rdy ? ($urandom_range(0, 3) != 0) : rdy_val;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  // Output monitor / scoreboard, sampled on the falling edge.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      stall_q = 0;
    end else begin
      chk("pkt_cnt", 64'(pkt_cnt_o), 64'(mdl_cnt));
      if (stall_q) begin
        chk("stall_valid", 64'(valid_o), 64'd1);
        chk("stall_data", data_o, held.data);
        chk("stall_flags", {62'd0, last_o, sop_o}, {62'd0, held.last, held.sop});
      end
      if (valid_o && ready_i) begin
        if (sb.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_beat: got data %0h, required no beat", data_o);
        end else begin
          beat_t e;
          e = sb.pop_front();
          chk("out_data", data_o, e.data);
          chk("out_flags", {62'd0, last_o, sop_o}, {62'd0, e.last, e.sop});
        end
        out_beats++;
        if (last_o) begin
          mdl_cnt = mdl_cnt + CNT_W'(1);
          last_pop_edge = cyc + 1;
        end
      end
      stall_q = valid_o && !ready_i;
      held = '{data: data_o, last: last_o, sop: sop_o};
    end
  end

  task automatic do_reset(input int n);
    rst_n = 1'b0; cmd_valid_i = 1'b0; in_valid_i = 1'b0;
    sb.delete(); mdl_cnt = '0; out_beats = 0;
    repeat (n) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_cmd_ready", 64'(cmd_ready_o), 64'd1);
    chk("rst_in_ready", 64'(in_ready_o), 64'd0);
    chk("rst_pkt_cnt", 64'(pkt_cnt_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic send_cmd(input int len, output int edge_n);
    cmd_valid_i = 1'b1; cmd_len_i = LEN_W'(len);
    edge_n = -1;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (cmd_ready_o) begin
        edge_n = cyc + 1;
        @(posedge clk); #1;
        cmd_valid_i = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    cmd_valid_i = 1'b0;
    n_chk++;
    $display("FAIL cmd_timeout: got no cmd_ready_o, required acceptance within 100 cycles");
  endtask

  task automatic drive_beats(input int first, input int total, input logic [63:0] base,
                             input int max_cyc, output int acc, output int fe, output int le);
    int idx;
    idx = first; acc = 0; fe = -1; le = -1;
    for (int t = 0; t < max_cyc && idx < total; t++) begin
      in_valid_i = 1'b1; in_data_i = base + 64'(idx);
      @(negedge clk);
      if (in_ready_o) begin
        sb.push_back('{data: base + 64'(idx), last: (idx == total - 1), sop: (idx == 0)});
        if (acc == 0) fe = cyc + 1;
        le = cyc + 1;
        idx++; acc++;
      end
      @(posedge clk); #1;
    end
    in_valid_i = 1'b0;
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy_o) begin
        @(posedge clk); #1;
        return;
      end
    end
    n_chk++;
    $display("FAIL drain_timeout: got %0d beats pending, required 0", sb.size());
    @(posedge clk); #1;
  endtask

  vec_t vt[5];
  int   ce, fe, le, acc;
  int   ce3[3], fe3[3];
  int   wrap_seq[5];

  initial begin
    vt[0] = '{len: 0,  base: 64'h10, rr: 0, exp_beats: 1,  exp_cnt: 1};
    vt[1] = '{len: 15, base: 64'h20, rr: 0, exp_beats: 16, exp_cnt: 2};
    vt[2] = '{len: 3,  base: 64'h40, rr: 1, exp_beats: 4,  exp_cnt: 3};
    vt[3] = '{len: 7,  base: 64'h60, rr: 1, exp_beats: 8,  exp_cnt: 0};
    vt[4] = '{len: 15, base: 64'h80, rr: 1, exp_beats: 16, exp_cnt: 1};
    wrap_seq = '{1, 2, 3, 0, 1};

    cmd_valid_i = 1'b0; cmd_len_i = '0; in_valid_i = 1'b0; in_data_i = '0; rst_n = 1'b0;

    // Reset state, then in_valid_i in IDLE must be ignored.
    do_reset(2);
    in_valid_i = 1'b1; in_data_i = 64'hDEAD;
    repeat (3) begin
      @(negedge clk);
      chk("idle_in_ready", 64'(in_ready_o), 64'd0);
      chk("idle_valid", 64'(valid_o), 64'd0);
      @(posedge clk); #1;
    end
    in_valid_i = 1'b0;

    // Single packet, full throughput.
    do_reset(1);
    send_cmd(3, ce);
    drive_beats(0, 4, 64'hA0, 50, acc, fe, le);
    chk("single_acc", 64'(acc), 64'd4);
    chk("single_first_edge", 64'(fe), 64'(ce + 1));
    chk("single_last_edge", 64'(le), 64'(ce + 4));
    wait_drain();
    chk("single_last_pop", 64'(last_pop_edge), 64'(ce + 5));
    chk("single_cnt", 64'(pkt_cnt_o), 64'd1);
    chk("single_busy", 64'(busy_o), 64'd0);

    // Back-to-back 1-beat packets: accepts every 2 cycles.
    do_reset(1);
    for (int k = 0; k < 3; k++) begin
      send_cmd(0, ce3[k]);
      drive_beats(0, 1, 64'h11 * 64'(k + 1), 20, acc, fe3[k], le);
      chk("b2b_latency", 64'(fe3[k]), 64'(ce3[k] + 1));
      if (k > 0) chk("b2b_spacing", 64'(fe3[k] - fe3[k-1]), 64'd2);
    end
    wait_drain();
    chk("b2b_cnt", 64'(pkt_cnt_o), 64'd3);

    // Counter wrap with a 2-bit counter.
    do_reset(1);
    for (int k = 0; k < 5; k++) begin
      send_cmd(0, ce);
      drive_beats(0, 1, 64'h100 + 64'(k), 20, acc, fe, le);
      wait_drain();
      chk("wrap_cnt", 64'(pkt_cnt_o), 64'(wrap_seq[k]));
    end

    // Back-pressure: only two beats fit, head holds during the stall.
    do_reset(1);
    rdy_val = 1'b0;
    send_cmd(7, ce);
    drive_beats(0, 8, 64'hB0, 5, acc, fe, le);
    chk("bp_acc", 64'(acc), 64'd2);
    @(negedge clk);
    chk("bp_in_ready", 64'(in_ready_o), 64'd0);
    chk("bp_head", data_o, 64'hB0);
    @(posedge clk); #1;
    rdy_val = 1'b1;
    drive_beats(2, 8, 64'hB0, 100, acc, fe, le);
    chk("bp_rest_acc", 64'(acc), 64'd6);
    wait_drain();
    chk("bp_out_beats", 64'(out_beats), 64'd8);

    // Reset mid-packet: 3 accepted, 1 popped, 2 buffered.
    do_reset(1);
    rdy_val = 1'b0;
    send_cmd(5, ce);
    drive_beats(0, 6, 64'hC0, 10, acc, fe, le);
    chk("mid_acc2", 64'(acc), 64'd2);
    rdy_val = 1'b1;
    @(posedge clk); #1;
    rdy_val = 1'b0;
    drive_beats(2, 6, 64'hC0, 3, acc, fe, le);
    chk("mid_acc3", 64'(acc), 64'd1);
    do_reset(1);
    rdy_val = 1'b1;
    send_cmd(1, ce);
    drive_beats(0, 2, 64'hD0, 20, acc, fe, le);
    wait_drain();
    chk("mid_cnt", 64'(pkt_cnt_o), 64'd1);

    // Table-driven packets, including max length and random back-pressure.
    do_reset(1);
    for (int i = 0; i < 5; i++) begin
      rand_rdy = vt[i].rr;
      out_beats = 0;
      send_cmd(vt[i].len, ce);
      drive_beats(0, vt[i].len + 1, vt[i].base, 300, acc, fe, le);
      chk("vec_acc", 64'(acc), 64'(vt[i].exp_beats));
      @(negedge clk);
      chk("vec_cmd_ready", 64'(cmd_ready_o), 64'd1);
      chk("vec_in_ready", 64'(in_ready_o), 64'd0);
      wait_drain();
      chk("vec_out_beats", 64'(out_beats), 64'(vt[i].exp_beats));
      chk("vec_cnt", 64'(pkt_cnt_o), 64'(vt[i].exp_cnt));
    end
    rand_rdy = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/aidc_pkt_framer.md
Name: aidc_pkt_framer

Overview:
- Framing stage placed directly upstream of the start-of-packet generator in the AIDC compression datapath.
- Takes an unframed beat stream plus a per-packet length command.
- Emits a valid/ready stream carrying data_o, last_o and sop_o.
- The downstream SOP tracker consumes valid_o/ready_i/last_o; sop_o is provided for cross-checking against it.
- Output is registered through a 2-entry buffer, so there is no combinational path from ready_i to any input-side ready.

Parameters:
DATA_W, 64, width of data beats
LEN_W, 4, width of packet length field; max packet = 2**LEN_W beats
CNT_W, 16, width of completed-packet counter

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
cmd_valid_i  input  1  length command valid
cmd_ready_o  output  1  length command accepted when high with cmd_valid_i
cmd_len_i  input  LEN_W  packet length in beats minus 1
in_valid_i  input  1  input beat valid
in_ready_o  output  1  input beat accepted when high with in_valid_i
in_data_i  input  DATA_W  input beat data
valid_o  output  1  output beat valid
ready_i  input  1  downstream ready
data_o  output  DATA_W  output beat data
last_o  output  1  final beat of packet
sop_o  output  1  first beat of packet
pkt_cnt_o  output  CNT_W  packets fully emitted on output (wraps)
busy_o  output  1  state XFER or buffer non-empty

Behaviour:
- Reset (rst_n low at clk edge), all registered; values visible the cycle after:
  - state = IDLE, remaining = 0, first = 1
  - buffer count = 0; valid_o = 0, cmd_ready_o = 1, in_ready_o = 0
  - pkt_cnt_o = 0, busy_o = 0
  - Reset mid-packet discards buffered beats and any partially transferred packet. No last_o is emitted for the discarded packet.
- FSM states: IDLE and XFER.
- IDLE:
  - cmd_ready_o = 1, in_ready_o = 0.
  - On cmd_valid_i & cmd_ready_o: remaining <= cmd_len_i, first <= 1, state <= XFER.
- XFER:
  - cmd_ready_o = 0; in_ready_o = (count < 2). in_ready_o does not depend on ready_i.
  - On in_valid_i & in_ready_o, push entry {in_data_i, last = (remaining == 0), sop = first}, then first <= 0.
  - If remaining == 0, state <= IDLE; else remaining <= remaining - 1.
- Command gap: a new command can be accepted no earlier than the cycle after the last input beat is accepted. This gives one idle input cycle between packets.
- cmd_len_i = 0 gives a 1-beat packet with sop = last = 1 on the same beat. cmd_len_i = 2**LEN_W - 1 gives the maximum 2**LEN_W beats.
- Buffer (2-entry FIFO, registered outputs):
  - valid_o = (count != 0); data_o/last_o/sop_o show the head entry.
  - Pop on valid_o & ready_i. Push and pop in the same cycle leave count unchanged, with FIFO order preserved.
  - Latency: a beat accepted at edge N is visible on the outputs after edge N, i.e. 1 cycle.
  - Push into an empty buffer with a simultaneous pop is not possible, since valid_o is 0 that cycle.
  - Full (count = 2): in_ready_o = 0 the next cycle. Data already accepted is never dropped.
  - Outputs hold stable while valid_o & !ready_i (AXI-style: valid never retracts, payload never changes).
- pkt_cnt_o increments by 1 on each output handshake with last_o = 1, and wraps 2**CNT_W - 1 -> 0.
- busy_o = (state == XFER) | (count != 0).
- Throughput: with ready_i held high, 1 beat per cycle within a packet.
- in_data_i is not checked. in_valid_i in IDLE is ignored, because in_ready_o = 0.

Test Plan:
- Single packet: cmd_len_i = 3, in_valid_i held high with data 0xA0..0xA3, ready_i = 1.
  - Required: cmd accepted at cycle 0; beats accepted at cycles 1-4.
  - Outputs at cycles 2-5 carry 0xA0..0xA3, with sop_o = 1 only on 0xA0 and last_o = 1 only on 0xA3.
  - pkt_cnt_o = 1 after cycle 5; busy_o = 0 from cycle 6.
- Back-pressure: cmd_len_i = 7, ready_i = 0 for 5 cycles, then 1.
  - Required: exactly 2 beats accepted, then in_ready_o = 0.
  - data_o holds the first beat unchanged throughout the stall.
  - All 8 beats eventually emitted, in order, with no duplicates.
- 1-beat packets back-to-back: three commands with cmd_len_i = 0, data 0x11/0x22/0x33.
  - Required: each output beat has sop_o = last_o = 1.
  - Input accepts occur every 2 cycles; pkt_cnt_o = 3.
- Max length: cmd_len_i = 15 (LEN_W = 4).
  - Required: 16 beats; last_o only on beat 16; remaining never wraps.
- Reset mid-packet: cmd_len_i = 5, rst_n low after 3 beats accepted, 2 of them buffered.
  - Required: valid_o = 0, count = 0, pkt_cnt_o = 0 the cycle after reset.
  - A following cmd_len_i = 1 yields a fresh packet whose first beat has sop_o = 1.
- Counter wrap (CNT_W = 2): 5 one-beat packets.
  - Required: pkt_cnt_o sequence 1, 2, 3, 0, 1.
